// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: standard mode numbers, sync polarity levels and
// helpers that derive frame totals and counter widths from the porch parameters.
package vga_timing_pkg;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // 640x480@60, 25.175 MHz pixel rate, negative syncs
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600@60, 40 MHz pixel rate, positive syncs
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int calc_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_pix_tick_gen.sv
// Pixel-rate enable generator: a registered one-clk pulse every CLK_DIV system
// clocks, replacing a derived pixel clock. Held cleared while en is low.
module pix_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pix_tick
);

    localparam int            CW   = calc_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    always_comb begin
        count_nxt = count + 1'b1;
        if (count == LAST) begin
            count_nxt = '0;
        end
    end

    // Tick is registered from the next count, so it is high for the whole clk
    // in which count sits at its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            pix_tick <= 1'b0;
        end else if (!en) begin
            count    <= '0;
            pix_tick <= 1'b0;
        end else begin
            count    <= count_nxt;
            pix_tick <= (count_nxt == LAST);
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: h/v counters advanced by the pixel tick, with syncs,
// active window, coordinates and line/frame strobes registered from next counts.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV  = 2,
    parameter int   H_ACTIVE = VGA640_H_ACTIVE,
    parameter int   H_FP     = VGA640_H_FP,
    parameter int   H_SYNC   = VGA640_H_SYNC,
    parameter int   H_BP     = VGA640_H_BP,
    parameter int   V_ACTIVE = VGA640_V_ACTIVE,
    parameter int   V_FP     = VGA640_V_FP,
    parameter int   V_SYNC   = VGA640_V_SYNC,
    parameter int   V_BP     = VGA640_V_BP,
    parameter logic SYNC_POL = SYNC_ACTIVE_LOW,
    localparam int  H_TOTAL  = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int  V_TOTAL  = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int  HW       = calc_width(H_TOTAL),
    localparam int  VW       = calc_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
        $error("vga_timing_ctrl: all timing parameters must be greater than zero");
    end

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0] h_cnt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_cnt;
    logic [VW-1:0] v_nxt;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_vis;
    logic          v_vis;
    logic          hs_act;
    logic          vs_act;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pix_tick (pix_tick)
    );

    // Decoding from the next counts lets every output land on the same edge
    // as the counters, so downstream sees no lag against the raster position.
    always_comb begin
        h_wrap = pix_tick && (h_cnt == H_LAST);
        v_wrap = h_wrap && (v_cnt == V_LAST);
        h_nxt  = h_cnt;
        v_nxt  = v_cnt;
        if (pix_tick) begin
            h_nxt = h_wrap ? '0 : h_cnt + 1'b1;
        end
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : v_cnt + 1'b1;
        end
        h_vis  = (h_nxt < H_VIS_END);
        v_vis  = (v_nxt < V_VIS_END);
        hs_act = (h_nxt >= H_SYNC_BEG) && (h_nxt <= H_SYNC_END);
        vs_act = (v_nxt >= V_SYNC_BEG) && (v_nxt <= V_SYNC_END);
    end

    // Counters park at the last position of the frame, so the first tick after
    // reset or enable wraps straight into a clean (0,0) with a frame strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
            video_on    <= h_vis && v_vis;
            x           <= (h_vis && v_vis) ? h_nxt : '0;
            y           <= (h_vis && v_vis) ? v_nxt : '0;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: default 640x480 timing, a short-frame variant
// of the same line timing, and a tiny high-polarity mode with a one-clk tick.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int sel        = 0;

    logic       rst_a = 1'b1, en_a = 1'b0;
    logic       rst_b = 1'b1, en_b = 1'b0;
    logic       rst_c = 1'b1, en_c = 1'b0;

    logic       a_pix_tick, a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start;
    logic [9:0] a_x, a_y;
    logic       b_pix_tick, b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start;
    logic [9:0] b_x;
    logic [3:0] b_y;
    logic       c_pix_tick, c_hsync, c_vsync, c_video_on, c_line_start, c_frame_start;
    logic [2:0] c_x, c_y;

    logic m_tick, m_hs, m_vs, m_von, m_ls, m_fs;

    vga_timing_ctrl dut_a (
        .clk (clk), .rst (rst_a), .en (en_a),
        .pix_tick (a_pix_tick), .hsync (a_hsync), .vsync (a_vsync), .video_on (a_video_on),
        .x (a_x), .y (a_y), .line_start (a_line_start), .frame_start (a_frame_start)
    );

    vga_timing_ctrl #(
        .CLK_DIV (1), .V_ACTIVE (8), .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) dut_b (
        .clk (clk), .rst (rst_b), .en (en_b),
        .pix_tick (b_pix_tick), .hsync (b_hsync), .vsync (b_vsync), .video_on (b_video_on),
        .x (b_x), .y (b_y), .line_start (b_line_start), .frame_start (b_frame_start)
    );

    vga_timing_ctrl #(
        .CLK_DIV (1), .SYNC_POL (1'b1),
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) dut_c (
        .clk (clk), .rst (rst_c), .en (en_c),
        .pix_tick (c_pix_tick), .hsync (c_hsync), .vsync (c_vsync), .video_on (c_video_on),
        .x (c_x), .y (c_y), .line_start (c_line_start), .frame_start (c_frame_start)
    );

    // Selected instance, with syncs normalised to "active" regardless of polarity
    always_comb begin
        m_tick = a_pix_tick; m_hs = ~a_hsync; m_vs = ~a_vsync;
        m_von  = a_video_on; m_ls = a_line_start; m_fs = a_frame_start;
        if (sel == 1) begin
            m_tick = b_pix_tick; m_hs = ~b_hsync; m_vs = ~b_vsync;
            m_von  = b_video_on; m_ls = b_line_start; m_fs = b_frame_start;
        end else if (sel == 2) begin
            m_tick = c_pix_tick; m_hs = c_hsync; m_vs = c_vsync;
            m_von  = c_video_on; m_ls = c_line_start; m_fs = c_frame_start;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int dut, input logic r, input logic e);
        case (dut)
            0:       begin rst_a = r; en_a = e; end
            1:       begin rst_b = r; en_b = e; end
            default: begin rst_c = r; en_c = e; end
        endcase
    endtask

    task automatic waitFrameStart(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_fs && n < 16);
    endtask

    // Called in a line_start cycle; runs to the next line_start cycle.
    task automatic measureLineA(input int exp_y);
        int clks = 0, ticks = 0, von = 0, hs_first = -1, hs_len = 0, fs_cnt = 0;
        do begin
            if (a_frame_start) fs_cnt++;
            if (a_pix_tick) begin
                if (ticks == 0)   checkOutput("a_y_line", 32'(a_y), exp_y);
                if (ticks == 639) checkOutput("a_x_639", 32'(a_x), 639);
                if (ticks == 640) checkOutput("a_x_blank", 32'(a_x), 0);
                if (a_video_on) von++;
                if (!a_hsync) begin
                    if (hs_first < 0) hs_first = ticks;
                    hs_len++;
                end
                ticks++;
            end
            clks++;
            @(negedge clk);
        end while (!a_line_start && clks < 4000);
        checkOutput("a_line_clks", clks, 1600);
        checkOutput("a_line_ticks", ticks, 800);
        checkOutput("a_line_video", von, 640);
        checkOutput("a_hsync_first", hs_first, 656);
        checkOutput("a_hsync_len", hs_len, 96);
        checkOutput("a_fs_width", fs_cnt, 1);
    endtask

    // Called in a frame_start cycle; runs to the next frame_start cycle.
    task automatic measureFrame(output int clks, output int lines, output int ticks,
                                output int von, output int hs_cnt, output int hs_first,
                                output int vs_cnt, output int vs_first, output int ls_period);
        clks = 0; lines = 0; ticks = 0; von = 0; hs_cnt = 0; hs_first = -1;
        vs_cnt = 0; vs_first = -1; ls_period = -1;
        do begin
            if (m_ls) begin
                lines++;
                if (lines == 2) ls_period = clks;
            end
            if (m_tick) ticks++;
            if (m_von) von++;
            if (m_hs) begin
                if (hs_first < 0) hs_first = clks;
                hs_cnt++;
            end
            if (m_vs) begin
                if (vs_first < 0) vs_first = clks;
                vs_cnt++;
            end
            clks++;
            @(negedge clk);
        end while (!m_fs && clks < 20000);
    endtask

    initial begin
        int n, g;
        int clks, lines, ticks, von, hs_cnt, hs_first, vs_cnt, vs_first, ls_period;

        repeat (3) @(negedge clk);
        checkOutput("a_rst_tick", 32'(a_pix_tick), 0);
        checkOutput("a_rst_hsync", 32'(a_hsync), 1);
        checkOutput("a_rst_vsync", 32'(a_vsync), 1);
        checkOutput("a_rst_video", 32'(a_video_on), 0);
        checkOutput("a_rst_x", 32'(a_x), 0);
        checkOutput("a_rst_y", 32'(a_y), 0);
        checkOutput("a_rst_ls", 32'(a_line_start), 0);
        checkOutput("a_rst_fs", 32'(a_frame_start), 0);
        checkOutput("c_rst_hsync", 32'(c_hsync), 0);
        checkOutput("c_rst_vsync", 32'(c_vsync), 0);

        applyStimulus(0, 1'b0, 1'b1);
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(2, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("a_first_tick", 32'(a_pix_tick), 1);
        checkOutput("a_fs_early", 32'(a_frame_start), 0);
        checkOutput("a_hsync_preframe", 32'(a_hsync), 1);
        @(negedge clk);
        checkOutput("a_fs_first", 32'(a_frame_start), 1);
        checkOutput("a_ls_first", 32'(a_line_start), 1);
        checkOutput("a_video_first", 32'(a_video_on), 1);
        checkOutput("a_x_first", 32'(a_x), 0);
        checkOutput("a_y_first", 32'(a_y), 0);
        checkOutput("a_tick_gap", 32'(a_pix_tick), 0);

        measureLineA(0);
        checkOutput("a_fs_line1", 32'(a_frame_start), 0);

        n = 0; g = 0;
        do begin
            if (a_pix_tick) n++;
            @(negedge clk);
            g++;
        end while (n < 300 && g < 2000);
        checkOutput("a_x_300", 32'(a_x), 300);
        checkOutput("a_y_300", 32'(a_y), 1);
        checkOutput("a_video_300", 32'(a_video_on), 1);

        applyStimulus(0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("a_dis_tick", 32'(a_pix_tick), 0);
        checkOutput("a_dis_hsync", 32'(a_hsync), 1);
        checkOutput("a_dis_vsync", 32'(a_vsync), 1);
        checkOutput("a_dis_video", 32'(a_video_on), 0);
        checkOutput("a_dis_x", 32'(a_x), 0);
        checkOutput("a_dis_y", 32'(a_y), 0);
        repeat (3) @(negedge clk);
        checkOutput("a_hold_tick", 32'(a_pix_tick), 0);
        checkOutput("a_hold_fs", 32'(a_frame_start), 0);

        sel = 0;
        applyStimulus(0, 1'b0, 1'b1);
        waitFrameStart(n);
        checkOutput("a_restart_lat", n, 2);
        checkOutput("a_restart_x", 32'(a_x), 0);
        checkOutput("a_restart_y", 32'(a_y), 0);
        checkOutput("a_restart_video", 32'(a_video_on), 1);

        n = 0;
        while (a_hsync !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("a_hsync_reach", n, 1312);
        checkOutput("a_hsync_blank", 32'(a_video_on), 0);
        #1 rst_a = 1'b1;
        #1;
        checkOutput("a_async_hsync", 32'(a_hsync), 1);
        checkOutput("a_async_vsync", 32'(a_vsync), 1);
        checkOutput("a_async_tick", 32'(a_pix_tick), 0);
        checkOutput("a_async_ls", 32'(a_line_start), 0);
        checkOutput("a_async_fs", 32'(a_frame_start), 0);
        #1 rst_a = 1'b0;
        waitFrameStart(n);
        checkOutput("a_post_rst_lat", n, 2);
        applyStimulus(0, 1'b0, 1'b0);

        sel = 1;
        applyStimulus(1, 1'b0, 1'b1);
        waitFrameStart(n);
        checkOutput("b_start_lat", n, 2);
        measureFrame(clks, lines, ticks, von, hs_cnt, hs_first, vs_cnt, vs_first, ls_period);
        checkOutput("b_frame_clks", clks, 12000);
        checkOutput("b_frame_ticks", ticks, 12000);
        checkOutput("b_frame_lines", lines, 15);
        checkOutput("b_line_period", ls_period, 800);
        checkOutput("b_frame_video", von, 5120);
        checkOutput("b_hsync_cnt", hs_cnt, 1440);
        checkOutput("b_hsync_first", hs_first, 656);
        checkOutput("b_vsync_cnt", vs_cnt, 1600);
        checkOutput("b_vsync_first", vs_first, 8000);
        checkOutput("b_wrap_ls", 32'(b_line_start), 1);
        checkOutput("b_wrap_x", 32'(b_x), 0);
        checkOutput("b_wrap_y", 32'(b_y), 0);
        checkOutput("b_wrap_video", 32'(b_video_on), 1);
        @(negedge clk);
        checkOutput("b_wrap_fs_width", 32'(b_frame_start), 0);
        applyStimulus(1, 1'b0, 1'b0);

        sel = 2;
        applyStimulus(2, 1'b0, 1'b1);
        waitFrameStart(n);
        checkOutput("c_start_lat", n, 2);
        measureFrame(clks, lines, ticks, von, hs_cnt, hs_first, vs_cnt, vs_first, ls_period);
        checkOutput("c_frame_clks", clks, 42);
        checkOutput("c_frame_ticks", ticks, 42);
        checkOutput("c_frame_lines", lines, 6);
        checkOutput("c_line_period", ls_period, 7);
        checkOutput("c_frame_video", von, 12);
        checkOutput("c_hsync_cnt", hs_cnt, 6);
        checkOutput("c_hsync_first", hs_first, 5);
        checkOutput("c_vsync_cnt", vs_cnt, 7);
        checkOutput("c_vsync_first", vs_first, 28);
        checkOutput("c_wrap_x", 32'(c_x), 0);
        checkOutput("c_wrap_y", 32'(c_y), 0);
        applyStimulus(2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
